// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel round-robin arbitrating mux with a registered output beat.
// Define RR_ARB_MUX_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module rr_arb_mux #(
  parameter  int NCH   = 8,
  parameter  int WIDTH = 32,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NCH-1:0]       i_req_valid,
  input  logic [NCH*WIDTH-1:0] i_req_data,
  output logic [NCH-1:0]       o_req_ready,
  output logic                 o_out_valid,
  output logic [WIDTH-1:0]     o_out_data,
  output logic [SELW-1:0]      o_out_sel,
  input  logic                 i_out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_sel;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
  logic [SELW-1:0]  r_last;
`endif

  logic             w_load_en;
  logic             w_any;
  logic             w_xfer;
  logic [SELW-1:0]  w_grant_idx;
  logic [NCH-1:0]   w_grant;
  logic [WIDTH-1:0] w_sel_data;

  assign w_load_en = !r_out_valid || i_out_ready;

  always_comb begin
    logic [SELW-1:0] w_idx;
    w_any       = 1'b0;
    w_grant_idx = '0;
    w_grant     = '0;
    w_idx       = '0;
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    for (int k = NCH - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        w_any       = 1'b1;
        w_grant_idx = SELW'(k);
      end
    end
`else
    // Search starts one past the last accepted channel and wraps at NCH.
    for (int k = 0; k < NCH; k++) begin
      w_idx = SELW'((int'(r_last) + 1 + k) % NCH);
      if (!w_any && i_req_valid[w_idx]) begin
        w_any       = 1'b1;
        w_grant_idx = w_idx;
      end
    end
`endif
    if (w_any) w_grant[w_grant_idx] = 1'b1;
  end

  assign w_xfer     = w_any && w_load_en;
  assign w_sel_data = i_req_data[w_grant_idx*WIDTH +: WIDTH];

  // Reset gating keeps every ready low while the block is held in reset.
  assign o_req_ready = w_grant & {NCH{w_load_en}} & {NCH{i_rst_n}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
      r_last      <= SELW'(NCH - 1);
`endif
    end else begin
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_sel   <= w_grant_idx;
`ifndef RR_ARB_MUX_FIXED_PRIO_EN
        r_last      <= w_grant_idx;
`endif
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_sel   = r_out_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - scoreboard bench for rr_arb_mux.
module tb_rr_arb_mux;
  localparam int NCH   = 8;
  localparam int WIDTH = 32;
  localparam int SELW  = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       req_valid;
  logic [NCH*WIDTH-1:0] req_data;
  logic [NCH-1:0]       req_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_ready;

  always #5 clk = ~clk;

  rr_arb_mux #(.NCH(NCH), .WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_out_valid (out_valid),
    .o_out_data  (out_data),
    .o_out_sel   (out_sel),
    .i_out_ready (out_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [SELW+WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0]      ch_data [NCH];
  int                    m_last;
  logic                  m_valid;
  logic [WIDTH-1:0]      m_data;
  logic [SELW-1:0]       m_sel;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [NCH-1:0] v);
    int p;
    p = -1;
`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    for (int c = NCH - 1; c >= 0; c--) if (v[c]) p = c;
`else
    for (int k = NCH; k >= 1; k--) if (v[(m_last + k) % NCH]) p = (m_last + k) % NCH;
`endif
    return p;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_last  = NCH - 1;
    m_data  = '0;
    m_sel   = '0;
    sb_q.delete();
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input logic [NCH-1:0] v, input logic rdy, output logic [NCH-1:0] obs_ready);
    int pick;
    logic load;
    logic [NCH-1:0] exp_ready;
    logic [SELW+WIDTH-1:0] e;
    req_valid = v;
    out_ready = rdy;
    for (int i = 0; i < NCH; i++) req_data[i*WIDTH +: WIDTH] = ch_data[i];
    @(negedge clk);
    pick = model_pick(v);
    load = !m_valid || rdy;
    exp_ready = '0;
    if (load && pick >= 0) exp_ready[pick] = 1'b1;
    obs_ready = req_ready;
    check("req_ready", req_ready, exp_ready);
    check("out_valid", out_valid, m_valid);
    if (m_valid && rdy) begin
      check("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_sel", out_sel, e[SELW+WIDTH-1:WIDTH]);
        check("sb_data", out_data, e[WIDTH-1:0]);
      end
    end
    if (load && pick >= 0) begin
      sb_q.push_back({SELW'(pick), ch_data[pick]});
      m_valid = 1'b1;
      m_sel   = SELW'(pick);
      m_data  = ch_data[pick];
      m_last  = pick;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (load && pick >= 0) ch_data[pick] = $urandom();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    #1;
    check("rst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sel", out_sel, 0);
    check("rst_ready_hold", req_ready, 0);
    req_valid = '0;
    rst_n     = 1'b1;
    model_reset();
  endtask

  logic [NCH-1:0]   obs;
  int               cnt [NCH];
  logic [WIDTH-1:0] saved;

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    for (int i = 0; i < NCH; i++) ch_data[i] = $urandom();
    for (int i = 0; i < NCH; i++) req_data[i*WIDTH +: WIDTH] = ch_data[i];
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    ch_data[0] = 32'hDEADBEEF;
    step(8'h01, 1'b1, obs);
    check("t1_ready", obs, 8'h01);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 32'hDEADBEEF);
    check("t1_sel", out_sel, 0);

`ifdef RR_ARB_MUX_FIXED_PRIO_EN
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(8'h06, 1'b1, obs);
      check("fixed_sel", out_sel, 1);
    end
`else
    do_reset();
    for (int c = 0; c < NCH; c++) cnt[c] = 0;
    for (int i = 0; i < 2 * NCH; i++) begin
      step(8'hFF, 1'b1, obs);
      check("fair_sel", out_sel, i % NCH);
      cnt[out_sel]++;
    end
    for (int c = 0; c < NCH; c++) check("fair_cnt", cnt[c], 2);

    saved = m_data;
    for (int i = 0; i < 5; i++) begin
      step(8'h0C, 1'b0, obs);
      check("hold_ready", obs, 0);
      check("hold_sel", out_sel, 7);
      check("hold_data", out_data, saved);
    end
    step(8'h0C, 1'b1, obs);
    check("refill_ready", obs, 8'h04);
    check("refill_valid", out_valid, 1);
    check("refill_sel", out_sel, 2);

    step(8'h80, 1'b1, obs);
    check("wrap_pre_sel", out_sel, 7);
    step(8'h81, 1'b1, obs);
    check("wrap_sel0", out_sel, 0);
    step(8'h81, 1'b1, obs);
    check("wrap_sel7", out_sel, 7);
`endif

    check("midrst_pre_valid", out_valid, 1);
    rst_n     = 1'b0;
    req_valid = '1;
    #1;
    check("midrst_async_valid", out_valid, 0);
    check("midrst_ready", req_ready, 0);
    @(posedge clk);
    #1;
    do_reset();
    step(8'hFF, 1'b1, obs);
    check("post_rst_ready", obs, 8'h01);
    check("post_rst_sel", out_sel, 0);

    for (int i = 0; i < 300; i++) begin
      step(NCH'($urandom()), ($urandom_range(0, 3) != 0), obs);
    end
    step('0, 1'b1, obs);
    step('0, 1'b1, obs);
    check("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
